// File: rtl/reg_operand_fetch_pkg.sv
// ---------------------------------------------------------------------------
// reg_operand_fetch_pkg
// Shared defines for the operand-fetch stage: default register address width,
// data width and register count, plus the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package reg_operand_fetch_pkg;

  localparam int REG_ADDR_DEF   = 3;
  localparam int REG_SIZE_DEF   = 16;
  localparam int REG_AMOUNT_DEF = 8;

  // One request in flight: accept, read the file, capture data, present it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/reg_operand_fetch_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Pending-write scoreboard for the operand-fetch stage.
//   clk, rst          : clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr  : mark set_addr as pending a write (accepted issue)
//   clr_en, clr_addr  : writeback retiring clr_addr
//   src1, src2, dest,
//   wr                : addresses of the request currently offered by decode
//   free              : request has no hazard against pending writes
//   busy              : bit n high = write to register n pending
// A register retiring this very cycle already counts as free for issue, and a
// set and clear of the same bit in one cycle leaves the bit set.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int REG_ADDR   = 3,
  parameter int REG_AMOUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR-1:0]   set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR-1:0]   clr_addr,
  input  logic [REG_ADDR-1:0]   src1,
  input  logic [REG_ADDR-1:0]   src2,
  input  logic [REG_ADDR-1:0]   dest,
  input  logic                  wr,
  output logic                  free,
  output logic [REG_AMOUNT-1:0] busy
);

  logic [REG_AMOUNT-1:0] set_mask;
  logic [REG_AMOUNT-1:0] clr_mask;
  logic [REG_AMOUNT-1:0] busy_issue;

  // Decode by comparison rather than indexing so a REG_AMOUNT smaller than
  // 2**REG_ADDR never produces an out-of-range bit select.
  // NOTE: every always_comb output gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int n = 0; n < REG_AMOUNT; n++) begin
      set_mask[n] = set_en && (set_addr == REG_ADDR'(n));
      clr_mask[n] = clr_en && (clr_addr == REG_ADDR'(n));
    end
  end

  assign busy_issue = busy & ~clr_mask;

  always_comb begin
    free = 1'b1;
    for (int n = 0; n < REG_AMOUNT; n++) begin
      if (busy_issue[n] &&
          ((src1 == REG_ADDR'(n)) || (src2 == REG_ADDR'(n)) ||
           (wr && (dest == REG_ADDR'(n))))) begin
        free = 1'b0;
      end
    end
  end

  // Clear first, then OR in the set so a same-cycle set wins.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/reg_operand_fetch.sv
// ---------------------------------------------------------------------------
// reg_operand_fetch
// Operand-fetch stage between decode and execute. Accepts one request at a
// time, reads both sources from an external register file (one-cycle read
// latency), and holds the operands until the consumer takes them. Writebacks
// pass straight through to the file's write port and retire scoreboard bits.
//   clk, rst                        : clock, synchronous active-high reset
//   issue_valid/issue_ready         : request handshake from decode
//   issue_src1/src2/dest, issue_wr  : request addresses, write intent
//   op_valid/op_ready               : operand handshake to the consumer
//   op_a, op_b, op_dest             : fetched operands, latched destination
//   wb_valid, wb_dest, wb_val       : writeback request
//   rf_src1, rf_src2, rf_read_en    : register-file read port
//   rf_reg1, rf_reg2                : read data, valid the cycle after sampling
//   rf_dest, rf_write_val,
//   rf_write_en                     : register-file write port (negedge commit)
//   busy                            : pending-write scoreboard
// ---------------------------------------------------------------------------
module reg_operand_fetch
  import reg_operand_fetch_pkg::*;
#(
  parameter int REG_ADDR   = REG_ADDR_DEF,
  parameter int REG_SIZE   = REG_SIZE_DEF,
  parameter int REG_AMOUNT = REG_AMOUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR-1:0]   issue_src1,
  input  logic [REG_ADDR-1:0]   issue_src2,
  input  logic [REG_ADDR-1:0]   issue_dest,
  input  logic                  issue_wr,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [REG_SIZE-1:0]   op_a,
  output logic [REG_SIZE-1:0]   op_b,
  output logic [REG_ADDR-1:0]   op_dest,
  input  logic                  wb_valid,
  input  logic [REG_ADDR-1:0]   wb_dest,
  input  logic [REG_SIZE-1:0]   wb_val,
  output logic [REG_ADDR-1:0]   rf_src1,
  output logic [REG_ADDR-1:0]   rf_src2,
  output logic                  rf_read_en,
  input  logic [REG_SIZE-1:0]   rf_reg1,
  input  logic [REG_SIZE-1:0]   rf_reg2,
  output logic [REG_ADDR-1:0]   rf_dest,
  output logic [REG_SIZE-1:0]   rf_write_val,
  output logic                  rf_write_en,
  output logic [REG_AMOUNT-1:0] busy
);

  fetch_state_t        state;
  logic [REG_ADDR-1:0] src1_q;
  logic [REG_ADDR-1:0] src2_q;
  logic [REG_ADDR-1:0] dest_q;
  logic                hazard_free;
  logic                handshake;

  // The write intent only matters to the scoreboard, which records it at the
  // handshake edge, so no copy of issue_wr is kept here.
  reg_scoreboard #(
    .REG_ADDR   (REG_ADDR),
    .REG_AMOUNT (REG_AMOUNT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (handshake && issue_wr),
    .set_addr (issue_dest),
    .clr_en   (wb_valid),
    .clr_addr (wb_dest),
    .src1     (issue_src1),
    .src2     (issue_src2),
    .dest     (issue_dest),
    .wr       (issue_wr),
    .free     (hazard_free),
    .busy     (busy)
  );

  // Ready must see a same-cycle writeback, so it stays combinational.
  assign issue_ready = (state == IDLE) && !rst && hazard_free;
  assign handshake   = issue_valid && issue_ready;

  // Writeback pass-through; the file commits on negedge, so a writeback up to
  // and including the READ cycle lands before the read sample.
  assign rf_write_en  = wb_valid && !rst;
  assign rf_dest      = wb_dest;
  assign rf_write_val = wb_val;

  assign rf_src1 = src1_q;
  assign rf_src2 = src2_q;

  // Outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      dest_q     <= '0;
      rf_read_en <= 1'b0;
      op_valid   <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_dest    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            src1_q     <= issue_src1;
            src2_q     <= issue_src2;
            dest_q     <= issue_dest;
            rf_read_en <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          rf_read_en <= 1'b0;
          state      <= LATCH;
        end
        LATCH: begin
          op_a     <= rf_reg1;
          op_b     <= rf_reg2;
          op_dest  <= dest_q;
          op_valid <= 1'b1;
          state    <= VALID;
        end
        VALID: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          rf_read_en <= 1'b0;
          op_valid   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_operand_fetch.md
REG_OPERAND_FETCH -- requirements
Module: reg_operand_fetch

Interface
REQ-001 SHALL have parameters: REG_ADDR, default 3, register address width; REG_SIZE, default 16, data width; REG_AMOUNT, default 8, register count.
REQ-002 clk  input  1  clock; all state on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 issue_valid  input  1  decode presents an operand request.
REQ-005 issue_ready  output  1  request accepted this cycle when high together with issue_valid.
REQ-006 issue_src1, issue_src2, issue_dest  input  REG_ADDR  source and destination addresses.
REQ-007 issue_wr  input  1  request will later write issue_dest.
REQ-008 op_valid  output  1  operands held on op_a/op_b/op_dest.
REQ-009 op_ready  input  1  consumer takes operands.
REQ-010 op_a, op_b  output  REG_SIZE  fetched operands; op_dest  output  REG_ADDR  latched destination.
REQ-011 wb_valid  input  1 ; wb_dest  input  REG_ADDR ; wb_val  input  REG_SIZE  writeback request.
REQ-012 rf_src1, rf_src2  output  REG_ADDR ; rf_read_en  output  1  register-file read port drive.
REQ-013 rf_reg1, rf_reg2  input  REG_SIZE  register-file read data, valid the cycle after the sampling posedge.
REQ-014 rf_dest  output  REG_ADDR ; rf_write_val  output  REG_SIZE ; rf_write_en  output  1  register-file write port drive; the file commits on negedge.
REQ-015 busy  output  REG_AMOUNT  scoreboard, bit n high = write to register n pending.

Function
REQ-016 FSM states IDLE, READ, LATCH, VALID; one request in flight.
REQ-017 A register counts as busy for issue when busy[n]=1 and not (wb_valid and wb_dest==n) in the same cycle.
REQ-018 issue_ready SHALL be 1 only in IDLE, rst low, src1 and src2 not busy, and (issue_wr=0 or dest not busy).
REQ-019 Handshake in IDLE: latch src1, src2, dest, wr; go READ.
REQ-020 READ: rf_read_en=1, rf_src1/rf_src2 = latched addresses; go LATCH. rf_read_en SHALL be 0 in all other states.
REQ-021 LATCH: op_a<=rf_reg1, op_b<=rf_reg2, op_dest<=latched dest; go VALID.
REQ-022 VALID: op_valid=1, op_a/op_b/op_dest stable; on op_ready go IDLE; op_valid low in all other states.
REQ-023 Latency: handshake in cycle T gives op_valid first high in T+3; throughput one request per 4 cycles with op_ready held high.
REQ-024 At handshake with wr=1, busy[dest] SHALL be set at that posedge.
REQ-025 wb_valid: rf_write_en=wb_valid, rf_dest=wb_dest, rf_write_val=wb_val, combinational, in every state; busy[wb_dest] cleared at posedge.
REQ-026 Set and clear of the same bit in one cycle: set wins (bit ends 1).
REQ-027 wb to a non-busy register SHALL write the file and leave busy unchanged.
REQ-028 A writeback in cycle T or T+1 to a source register SHALL appear in op_a/op_b (negedge write precedes READ posedge sample).
REQ-029 op_ready while not VALID SHALL be ignored.

Reset
REQ-030 While rst=1: state IDLE, busy=0, op_valid=0, op_a=op_b=0, op_dest=0, issue_ready=0, rf_read_en=0, rf_write_en=0.
REQ-031 Reset mid-request SHALL discard the request; no operand delivered, scoreboard cleared.

Structure
REQ-032 REG_ADDR, REG_SIZE, REG_AMOUNT defaults and FSM state encodings SHALL live in the shared defines file.
REQ-033 Scoreboard (busy vector, set/clear priority, busy-for-issue) SHALL be sub-module reg_scoreboard; FSM and datapath stay in reg_operand_fetch.

Verification
REQ-034 Basic fetch: file r1=0x1234, r2=0x00FF; issue src1=1, src2=2, dest=3, wr=1 at T -> op_valid at T+3, op_a=0x1234, op_b=0x00FF, op_dest=3, busy=0x08.
REQ-035 RAW stall: busy[3]=1, issue src1=3 -> issue_ready=0 until wb_valid, wb_dest=3, wb_val=0xBEEF; handshake in that same cycle -> op_a=0xBEEF.
REQ-036 Set/clear collision: busy[5]=1, wb_dest=5 with issue dest=5, wr=1 same cycle -> busy[5]=1 after the edge.
REQ-037 Backpressure: op_ready low 5 cycles in VALID -> op_valid and op_a/op_b stable; issue_ready=0 throughout; op_ready high -> IDLE next cycle.
REQ-038 Reset mid-op: rst in LATCH -> next cycle op_valid=0, busy=0, rf_read_en=0; new issue accepted the cycle after rst falls.
REQ-039 Stray writeback: wb to non-busy r6=0x0042 -> rf_write_en=1, busy unchanged; later fetch of r6 -> op_a=0x0042.
